lfa_nav_controller: RTL and testbench

LFA_NAV_CONTROLLER -- requirements
Module: lfa_nav_controller

---
 rtl/lfa_nav_if.sv | 37 +++
 rtl/lfa_nav_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_lfa_nav_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lfa_nav_if.sv
// Sensor, command and motor signal bundle for the line-follower navigation block.
// The master drives sensors and commands; the slave drives motors and status.
interface lfa_nav_if #(
    parameter int ADC_W  = 12,
    parameter int DUTY_W = 5,
    parameter int CNT_W  = 8
) ();
    logic [ADC_W-1:0]  left;
    logic [ADC_W-1:0]  middle;
    logic [ADC_W-1:0]  right;
    logic [1:0]        turn_cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              end_path;
    logic              m1_a;
    logic              m1_b;
    logic              m2_a;
    logic              m2_b;
    logic [DUTY_W-1:0] dc1;
    logic [DUTY_W-1:0] dc2;
    logic              node_flag;
    logic              node_changed;
    logic [CNT_W-1:0]  node_count;
    logic              fault;

    modport master (
        output left, middle, right, turn_cmd, cmd_valid, end_path,
        input  cmd_ready, m1_a, m1_b, m2_a, m2_b, dc1, dc2,
        input  node_flag, node_changed, node_count, fault
    );

    modport slave (
        input  left, middle, right, turn_cmd, cmd_valid, end_path,
        output cmd_ready, m1_a, m1_b, m2_a, m2_b, dc1, dc2,
        output node_flag, node_changed, node_count, fault
    );
endinterface

// File: rtl/lfa_nav_controller.sv
// Line-follower navigation: sensor pattern decode, node debounce, turn sequencing.
// Every output is a single register stage away from the sampled sensors.
module lfa_nav_controller #(
    parameter int ADC_W        = 12,
    parameter int HI_TH        = 1000,
    parameter int LO_TH        = 200,
    parameter int DUTY_W       = 5,
    parameter int DEBOUNCE     = 8,
    parameter int TURN_MIN     = 3125,
    parameter int TURN_TIMEOUT = 31250,
    parameter int LOST_CYC     = 1563,
    parameter int CNT_W        = 8
) (
    input logic     clk_3125KHz,
    input logic     reset,
    lfa_nav_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int TC_W = $clog2(TURN_TIMEOUT + 1);
    localparam int LC_W = $clog2(LOST_CYC + 1);

    localparam logic [DUTY_W-1:0] D5  = DUTY_W'(5);
    localparam logic [DUTY_W-1:0] D10 = DUTY_W'(10);
    localparam logic [DUTY_W-1:0] D12 = DUTY_W'(12);
    localparam logic [DUTY_W-1:0] D18 = DUTY_W'(18);
    localparam logic [DUTY_W-1:0] D20 = DUTY_W'(20);
    localparam logic [DUTY_W-1:0] D22 = DUTY_W'(22);

    typedef enum logic [2:0] {
        S_FOLLOW, S_NODE, S_WAIT, S_TURN, S_STOP, S_LOST
    } state_t;

    typedef enum logic [2:0] {
        P_NODE, P_DRIFT_R, P_DRIFT_L, P_ALL_W, P_STRAIGHT, P_AMBIG
    } pat_t;

    state_t            r_state;
    state_t            w_state;
    pat_t              w_pat;
    logic [3:0]        r_dir;
    logic [3:0]        w_dir;
    logic [DUTY_W-1:0] r_dc1;
    logic [DUTY_W-1:0] r_dc2;
    logic [DUTY_W-1:0] w_dc1;
    logic [DUTY_W-1:0] w_dc2;
    logic              r_flag;
    logic              r_chg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;
    logic              r_rdy;
    logic              r_buf_v;
    logic              w_buf_v;
    logic [1:0]        r_buf_cmd;
    logic [1:0]        w_buf_cmd;
    logic [1:0]        r_cmd;
    logic [1:0]        w_cmd;
    logic [DB_W-1:0]   r_dbc;
    logic [DB_W-1:0]   w_dbc;
    logic [TC_W-1:0]   r_tcnt;
    logic [TC_W-1:0]   w_tcnt;
    logic [LC_W-1:0]   r_lost;
    logic [LC_W-1:0]   w_lost;
    logic              w_done;
    logic              w_xfer;
    logic              w_lb, w_mb, w_rb;
    logic              w_lw, w_mw, w_rw;

    assign w_lb = bus.left   > ADC_W'(HI_TH);
    assign w_mb = bus.middle > ADC_W'(HI_TH);
    assign w_rb = bus.right  > ADC_W'(HI_TH);
    assign w_lw = bus.left   < ADC_W'(LO_TH);
    assign w_mw = bus.middle < ADC_W'(LO_TH);
    assign w_rw = bus.right  < ADC_W'(LO_TH);

    always_comb begin
        w_pat = P_AMBIG;
        if (w_lb && w_mb && w_rb)      w_pat = P_NODE;
        else if (w_rb && w_lw)         w_pat = P_DRIFT_R;
        else if (w_lb && w_rw)         w_pat = P_DRIFT_L;
        else if (w_lw && w_mw && w_rw) w_pat = P_ALL_W;
        else if (w_lw && w_mb && w_rw) w_pat = P_STRAIGHT;
    end

    assign w_xfer = bus.cmd_valid & r_rdy;

    always_comb begin
        w_state   = r_state;
        w_buf_v   = r_buf_v;
        w_buf_cmd = r_buf_cmd;
        w_cmd     = r_cmd;
        w_dbc     = '0;
        w_tcnt    = '0;
        w_lost    = '0;
        w_done    = 1'b0;
        unique case (r_state)
            S_FOLLOW: begin
                if (w_pat == P_NODE) begin
                    w_state = S_NODE;
                    w_dbc   = DB_W'(1);
                end else if (w_pat == P_ALL_W) begin
                    if (r_lost == LC_W'(LOST_CYC - 1)) w_state = S_LOST;
                    else w_lost = r_lost + 1'b1;
                end
            end
            S_NODE: begin
                if (w_pat != P_NODE) begin
                    w_state = S_FOLLOW;
                end else if (r_dbc == DB_W'(DEBOUNCE - 1)) begin
                    if (r_buf_v) begin
                        w_state = S_TURN;
                        w_cmd   = r_buf_cmd;
                        w_buf_v = 1'b0;
                    end else begin
                        w_state = S_WAIT;
                    end
                end else begin
                    w_dbc = r_dbc + 1'b1;
                end
            end
            S_WAIT: begin
                // a command that slipped in on the confirm cycle sits in the buffer
                if (r_buf_v) begin
                    w_state = S_TURN;
                    w_cmd   = r_buf_cmd;
                    w_buf_v = 1'b0;
                end else if (w_xfer) begin
                    w_state = S_TURN;
                    w_cmd   = bus.turn_cmd;
                end
            end
            S_TURN: begin
                if (r_tcnt >= TC_W'(TURN_MIN) && w_pat == P_STRAIGHT) begin
                    w_state = S_FOLLOW;
                    w_done  = 1'b1;
                end else if (r_tcnt == TC_W'(TURN_TIMEOUT - 1)) begin
                    w_state = S_LOST;
                end else begin
                    w_tcnt = r_tcnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (w_xfer && r_state != S_WAIT) begin
            w_buf_v   = 1'b1;
            w_buf_cmd = bus.turn_cmd;
        end
        if (bus.end_path) begin
            w_state   = S_STOP;
            w_done    = 1'b0;
            w_buf_v   = r_buf_v;
            w_buf_cmd = r_buf_cmd;
            w_cmd     = r_cmd;
        end
    end

    always_comb begin
        w_dir = r_dir;
        w_dc1 = r_dc1;
        w_dc2 = r_dc2;
        unique case (w_state)
            S_FOLLOW, S_NODE: begin
                // ambiguous and all-white samples keep whatever was driven last
                case (w_pat)
                    P_NODE, P_STRAIGHT: begin
                        w_dir = 4'b1010; w_dc1 = D10; w_dc2 = D10;
                    end
                    P_DRIFT_R: begin
                        w_dir = 4'b1010; w_dc1 = D20; w_dc2 = D10;
                    end
                    P_DRIFT_L: begin
                        w_dir = 4'b1010; w_dc1 = D10; w_dc2 = D20;
                    end
                    default: ;
                endcase
            end
            S_TURN: begin
                unique case (w_cmd)
                    2'd0: begin w_dir = 4'b1010; w_dc1 = D10; w_dc2 = D10; end
                    2'd1: begin w_dir = 4'b1001; w_dc1 = D18; w_dc2 = D5;  end
                    2'd2: begin w_dir = 4'b1001; w_dc1 = D12; w_dc2 = D22; end
                    2'd3: begin w_dir = 4'b0110; w_dc1 = D5;  w_dc2 = D18; end
                endcase
            end
            default: begin
                w_dir = 4'b0000; w_dc1 = '0; w_dc2 = '0;
            end
        endcase
    end

    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            r_state   <= S_FOLLOW;
            r_dir     <= '0;
            r_dc1     <= '0;
            r_dc2     <= '0;
            r_flag    <= 1'b0;
            r_chg     <= 1'b0;
            r_cnt     <= '0;
            r_fault   <= 1'b0;
            r_rdy     <= 1'b0;
            r_buf_v   <= 1'b0;
            r_buf_cmd <= '0;
            r_cmd     <= '0;
            r_dbc     <= '0;
            r_tcnt    <= '0;
            r_lost    <= '0;
        end else begin
            r_state   <= w_state;
            r_dir     <= w_dir;
            r_dc1     <= w_dc1;
            r_dc2     <= w_dc2;
            r_flag    <= (w_state == S_NODE) || (w_state == S_TURN);
            r_chg     <= w_done;
            if (w_done) r_cnt <= r_cnt + 1'b1;
            r_fault   <= r_fault | (w_state == S_LOST);
            r_rdy     <= !w_buf_v && w_state != S_STOP && w_state != S_LOST;
            r_buf_v   <= w_buf_v;
            r_buf_cmd <= w_buf_cmd;
            r_cmd     <= w_cmd;
            r_dbc     <= w_dbc;
            r_tcnt    <= w_tcnt;
            r_lost    <= w_lost;
        end
    end

    assign bus.m1_a         = r_dir[3];
    assign bus.m1_b         = r_dir[2];
    assign bus.m2_a         = r_dir[1];
    assign bus.m2_b         = r_dir[0];
    assign bus.dc1          = r_dc1;
    assign bus.dc2          = r_dc2;
    assign bus.node_flag    = r_flag;
    assign bus.node_changed = r_chg;
    assign bus.node_count   = r_cnt;
    assign bus.fault        = r_fault;
    assign bus.cmd_ready    = r_rdy;
endmodule

// File: tb/tb_lfa_nav_controller.sv
// Directed bench for lfa_nav_controller with shortened turn/lost timing.
// Expected output vectors are queued when a step is driven and popped after the edge.
module tb_lfa_nav_controller;
    localparam int TMIN = 20;
    localparam int TTO  = 60;
    localparam int LOST = 30;

    localparam logic [35:0] PS = {12'd100,  12'd2000, 12'd100};
    localparam logic [35:0] PN = {12'd2000, 12'd2000, 12'd2000};
    localparam logic [35:0] PW = {12'd100,  12'd100,  12'd100};
    localparam logic [35:0] PR = {12'd100,  12'd500,  12'd2000};
    localparam logic [35:0] PL = {12'd2000, 12'd500,  12'd100};
    localparam logic [35:0] PA = {12'd500,  12'd500,  12'd500};

    typedef struct {
        string       tag;
        logic [25:0] v;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    lfa_nav_if #(.ADC_W(12), .DUTY_W(5), .CNT_W(8)) bus ();

    lfa_nav_controller #(
        .TURN_MIN(TMIN),
        .TURN_TIMEOUT(TTO),
        .LOST_CYC(LOST)
    ) dut (
        .clk_3125KHz(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] mk(
        input logic [3:0] m, input int d1, input int d2, input logic f,
        input logic c, input int n, input logic flt, input logic rdy);
        return {m, 5'(d1), 5'(d2), f, c, 8'(n), flt, rdy};
    endfunction

    function automatic logic [25:0] obs();
        return {bus.m1_a, bus.m1_b, bus.m2_a, bus.m2_b, bus.dc1, bus.dc2,
                bus.node_flag, bus.node_changed, bus.node_count,
                bus.fault, bus.cmd_ready};
    endfunction

    task automatic check_pop();
        exp_t x;
        logic [25:0] o;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            x = sb.pop_front();
            o = obs();
            assert (o === x.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", x.tag, o, x.v);
            end
        end
    endtask

    task automatic drive(input logic [35:0] p, input logic v,
                         input logic [1:0] c, input logic ep);
        bus.left      = p[35:24];
        bus.middle    = p[23:12];
        bus.right     = p[11:0];
        bus.cmd_valid = v;
        bus.turn_cmd  = c;
        bus.end_path  = ep;
    endtask

    task automatic step(input logic [35:0] p, input logic v = 1'b0,
                        input logic [1:0] c = 2'd0, input logic ep = 1'b0);
        drive(p, v, c, ep);
        @(posedge clk);
        #1;
    endtask

    task automatic stepc(input string tag, input logic [25:0] e,
                         input logic [35:0] p, input logic v = 1'b0,
                         input logic [1:0] c = 2'd0, input logic ep = 1'b0);
        sb.push_back('{tag, e});
        step(p, v, c, ep);
        check_pop();
    endtask

    task automatic do_reset();
        drive(PS, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        sb.push_back('{"reset_async", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0)});
        check_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stepc("rdy_after_reset", mk(4'b1010, 10, 10, 0, 0, 0, 0, 1), PS);
    endtask

    task automatic node_cycle(input logic [1:0] c);
        step(PS, 1'b1, c);
        repeat (8) step(PN);
        repeat (TMIN + 1) step(PS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        drive(PS, 1'b0, 2'd0, 1'b0);
        #2;
        do_reset();

        stepc("straight",   mk(4'b1010, 10, 10, 0, 0, 0, 0, 1), PS);
        stepc("drift_r",    mk(4'b1010, 20, 10, 0, 0, 0, 0, 1), PR);
        stepc("ambig_hold", mk(4'b1010, 20, 10, 0, 0, 0, 0, 1), PA);
        stepc("drift_l",    mk(4'b1010, 10, 20, 0, 0, 0, 0, 1), PL);
        stepc("allw_hold",  mk(4'b1010, 10, 20, 0, 0, 0, 0, 1), PW);
        stepc("straight2",  mk(4'b1010, 10, 10, 0, 0, 0, 0, 1), PS);

        stepc("cmd_buffered", mk(4'b1010, 10, 10, 0, 0, 0, 0, 0), PS, 1'b1, 2'd1);
        repeat (6) step(PN);
        stepc("node7",      mk(4'b1010, 10, 10, 1, 0, 0, 0, 0), PN);
        stepc("node_abort", mk(4'b1010, 10, 10, 0, 0, 0, 0, 0), PS);
        repeat (7) step(PN);
        stepc("turn_right", mk(4'b1001, 18, 5, 1, 0, 0, 0, 1), PN);
        repeat (TMIN - 1) step(PS);
        stepc("turn_hold",  mk(4'b1001, 18, 5, 1, 0, 0, 0, 1), PS);
        stepc("reacquire",  mk(4'b1010, 10, 10, 0, 1, 1, 0, 1), PS);
        stepc("chg_once",   mk(4'b1010, 10, 10, 0, 0, 1, 0, 1), PS);

        repeat (7) step(PN);
        stepc("wait_cmd",   mk(4'b0000, 0, 0, 0, 0, 1, 0, 1), PN);
        stepc("turn_left",  mk(4'b0110, 5, 18, 1, 0, 1, 0, 1), PS, 1'b1, 2'd3);
        repeat (TMIN) step(PS);
        stepc("reacq2",     mk(4'b1010, 10, 10, 0, 1, 2, 0, 1), PS);

        step(PS, 1'b1, 2'd2);
        repeat (7) step(PN);
        stepc("turn_u",       mk(4'b1001, 12, 22, 1, 0, 2, 0, 1), PN);
        repeat (TTO - 1) step(PN);
        stepc("turn_timeout", mk(4'b0000, 0, 0, 0, 0, 2, 1, 0), PN);
        stepc("lost_hold",    mk(4'b0000, 0, 0, 0, 0, 2, 1, 0), PS);

        do_reset();
        repeat (LOST - 2) step(PW);
        stepc("allw_pre",   mk(4'b1010, 10, 10, 0, 0, 0, 0, 1), PW);
        stepc("lost_allw",  mk(4'b0000, 0, 0, 0, 0, 0, 1, 0), PW);
        stepc("lost_stay",  mk(4'b0000, 0, 0, 0, 0, 0, 1, 0), PS);

        do_reset();
        step(PS, 1'b1, 2'd1);
        repeat (7) step(PN);
        stepc("ep_confirm", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0), PN, 1'b0, 2'd0, 1'b1);
        stepc("stop_stay",  mk(4'b0000, 0, 0, 0, 0, 0, 0, 0), PS);

        do_reset();
        repeat (255) node_cycle(2'd0);
        stepc("cnt255",     mk(4'b1010, 10, 10, 0, 0, 255, 0, 1), PS);
        step(PS, 1'b1, 2'd0);
        repeat (7) step(PN);
        stepc("turn_straight", mk(4'b1010, 10, 10, 1, 0, 255, 0, 1), PN);
        repeat (TMIN) step(PS);
        stepc("wrap",       mk(4'b1010, 10, 10, 0, 1, 0, 0, 1), PS);

        step(PS, 1'b1, 2'd2);
        repeat (8) step(PN);
        stepc("turn_buffer", mk(4'b1001, 12, 22, 1, 0, 0, 0, 0), PS, 1'b1, 2'd1);
        do_reset();
        repeat (7) step(PN);
        stepc("buf_discard", mk(4'b0000, 0, 0, 0, 0, 0, 0, 1), PN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
